// File: rtl/collision_scan.sv
// Collision scan sequencer: walks the 4x4 piece window through the external index
// stage and playfield RAM, and reports whether the candidate placement collides.
module collision_scan #(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  pos_x,
  input  logic [4:0]  pos_y,
  input  logic [9:0]  rot,
  input  logic [15:0] shape,
  output logic [4:0]  pos_x_o,
  output logic [4:0]  pos_y_o,
  output logic [9:0]  rot_o,
  output logic [1:0]  b_x,
  output logic [1:0]  b_y,
  input  logic [3:0]  block_index,
  input  logic [8:0]  field_index,
  output logic [8:0]  field_rd_addr,
  input  logic        field_rd_data,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        drain_r;
  logic [15:0] shape_r;

  logic        vld_d1_r;
  logic        vld_d2_r;
  logic [1:0]  b_x_d1_r;
  logic [1:0]  b_y_d1_r;
  logic [1:0]  b_x_d2_r;
  logic [1:0]  b_y_d2_r;
  logic        shape_bit_r;

  logic        accept_s;
  logic [5:0]  cell_x_s;
  logic [5:0]  cell_y_s;
  logic        hit_s;

  // A cell outside the playfield is a wall or floor hit regardless of RAM contents.
  function automatic logic cell_oob(input logic [5:0] x, input logic [5:0] y);
    cell_oob = (x >= 6'(FIELD_W)) || (y >= 6'(FIELD_H));
  endfunction

  assign field_rd_addr = field_index;

  // Start acceptance and per-cell hit evaluation for the cell leaving the pipeline.
  always_comb begin
    accept_s = 1'b0;
    cell_x_s = 6'd0;
    cell_y_s = 6'd0;
    hit_s    = 1'b0;
    if (state_r == IDLE) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    cell_x_s = {1'b0, pos_x_o} + {4'b0000, b_x_d2_r};
    cell_y_s = {1'b0, pos_y_o} + {4'b0000, b_y_d2_r};
    hit_s    = shape_bit_r & (cell_oob(cell_x_s, cell_y_s) | field_rd_data);
  end

  // Sequencer FSM: latches the request, drives cell coordinates, times the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      drain_r <= 1'b0;
      shape_r <= 16'd0;
      pos_x_o <= 5'd0;
      pos_y_o <= 5'd0;
      rot_o   <= 10'd0;
      b_x     <= 2'd0;
      b_y     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            pos_x_o <= pos_x;
            pos_y_o <= pos_y;
            rot_o   <= rot;
            shape_r <= shape;
            cnt_r   <= 4'd0;
            b_x     <= 2'd0;
            b_y     <= 2'd0;
            busy    <= 1'b1;
            state_r <= SCAN;
          end else begin
            busy    <= 1'b0;
          end
        end
        SCAN: begin
          if (cnt_r == 4'd15) begin
            b_x     <= 2'd0;
            b_y     <= 2'd0;
            drain_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            cnt_r <= cnt_r + 4'd1;
            {b_y, b_x} <= cnt_r + 4'd1;
          end
        end
        DRAIN: begin
          // Two cycles let the last cell's index and RAM data reach the hit logic.
          if (drain_r) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            drain_r <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Alignment pipeline: matches cell coordinates and shape bit to the RAM data latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_d1_r    <= 1'b0;
      vld_d2_r    <= 1'b0;
      b_x_d1_r    <= 2'd0;
      b_y_d1_r    <= 2'd0;
      b_x_d2_r    <= 2'd0;
      b_y_d2_r    <= 2'd0;
      shape_bit_r <= 1'b0;
    end else begin
      vld_d1_r    <= (state_r == SCAN);
      vld_d2_r    <= vld_d1_r;
      b_x_d1_r    <= b_x;
      b_y_d1_r    <= b_y;
      b_x_d2_r    <= b_x_d1_r;
      b_y_d2_r    <= b_y_d1_r;
      shape_bit_r <= shape_r[block_index];
    end
  end

  // Collision accumulator: cleared on acceptance, held after the scan completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else if (accept_s) begin
      collision <= 1'b0;
    end else if (vld_d2_r) begin
      collision <= collision | hit_s;
    end else begin
      collision <= collision;
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Directed bench for collision_scan with a behavioural index stage and playfield RAM
// (column-major field index: x*20 + y).
module tb_collision_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  pos_x, pos_y, pos_x_o, pos_y_o;
  logic [9:0]  rot, rot_o;
  logic [15:0] shape;
  logic [1:0]  b_x, b_y;
  logic [3:0]  block_index;
  logic [8:0]  field_index, field_rd_addr;
  logic        field_rd_data;
  logic        busy, done, collision;

  logic [199:0] field_mem;
  int checks = 0;
  int errors = 0;

  collision_scan #(.FIELD_W(10), .FIELD_H(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .shape(shape),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .rot_o(rot_o),
    .b_x(b_x), .b_y(b_y),
    .block_index(block_index), .field_index(field_index),
    .field_rd_addr(field_rd_addr), .field_rd_data(field_rd_data),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  // Index stage (rotation 0 / multiples of 4) and playfield RAM, both 1-cycle latency.
  always @(posedge clk) begin
    block_index   <= {b_y, b_x};
    field_index   <= 9'((int'(pos_x_o) + int'(b_x)) * 20 + int'(pos_y_o) + int'(b_y));
    field_rd_data <= (field_rd_addr < 9'd200) ? field_mem[field_rd_addr] : 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for the edge that follows; returns in cycle 1.
  task automatic start_scan(input logic [4:0] px, input logic [4:0] py,
                            input logic [9:0] r, input logic [15:0] sh);
    pos_x = px; pos_y = py; rot = r; shape = sh; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // From cycle 1, wait (bounded) for done; then step into the following IDLE cycle.
  task automatic wait_done(output int dc, output logic coll);
    dc = -1;
    coll = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if (done === 1'b1) begin
        dc = k;
        coll = collision;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    pos_x = 5'd0; pos_y = 5'd0; rot = 10'd0; shape = 16'd0;
    field_mem = '0;
    step(); step();
    checks++;
    if ({busy, done, collision, b_x, b_y} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/coll/bx/by=%b expected 0000000", {busy, done, collision, b_x, b_y});
    end
    checks++;
    if ({pos_x_o, pos_y_o, rot_o} !== 20'd0) begin
      errors++;
      $display("FAIL reset_latched: %h expected 0", {pos_x_o, pos_y_o, rot_o});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    field_mem = '0;
    start_scan(5'd0, 5'd0, 10'd0, 16'h0033);
    for (int k = 1; k <= 20; k++) begin
      checks++;
      if (busy !== (k <= 19) || done !== (k == 19)) begin
        errors++;
        $display("FAIL basic_timing cycle %0d: busy=%b done=%b expected busy=%b done=%b",
                 k, busy, done, k <= 19, k == 19);
      end
      if (k <= 16) begin
        checks++;
        if ({b_y, b_x} !== 4'(k - 1)) begin
          errors++;
          $display("FAIL basic_cell cycle %0d: {b_y,b_x}=%0d expected %0d", k, {b_y, b_x}, k - 1);
        end
      end
      if (k == 19) begin
        checks++;
        if (collision !== 1'b0) begin
          errors++;
          $display("FAIL basic_collision: %b expected 0", collision);
        end
      end
      step();
    end
  endtask

  task automatic test_settled();
    int dc; logic coll;
    field_mem = '0;
    field_mem[21] = 1'b1;
    start_scan(5'd0, 5'd0, 10'd4, 16'h0033);
    checks++;
    if (rot_o !== 10'd4) begin
      errors++;
      $display("FAIL settled_rot_o: %0d expected 4", rot_o);
    end
    wait_done(dc, coll);
    checks++;
    if (dc !== 19 || coll !== 1'b1) begin
      errors++;
      $display("FAIL settled_hit: done_cycle=%0d coll=%b expected 19/1", dc, coll);
    end
    checks++;
    if (collision !== 1'b1) begin
      errors++;
      $display("FAIL settled_hold: %b expected 1", collision);
    end
    field_mem[21] = 1'b0;
    field_mem[22] = 1'b1;
    start_scan(5'd0, 5'd0, 10'd0, 16'h0033);
    wait_done(dc, coll);
    checks++;
    if (dc !== 19 || coll !== 1'b0) begin
      errors++;
      $display("FAIL settled_miss: done_cycle=%0d coll=%b expected 19/0", dc, coll);
    end
  endtask

  task automatic test_wall_floor();
    int dc; logic coll;
    field_mem = '0;
    start_scan(5'd7, 5'd0, 10'd0, 16'h000F);
    wait_done(dc, coll);
    checks++;
    if (dc !== 19 || coll !== 1'b1) begin
      errors++;
      $display("FAIL wall_hit: done_cycle=%0d coll=%b expected 19/1", dc, coll);
    end
    start_scan(5'd6, 5'd0, 10'd0, 16'h000F);
    wait_done(dc, coll);
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL wall_clear: coll=%b expected 0", coll);
    end
    start_scan(5'd0, 5'd19, 10'd0, 16'h0033);
    wait_done(dc, coll);
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL floor_hit: coll=%b expected 1", coll);
    end
    start_scan(5'd0, 5'd18, 10'd0, 16'h0033);
    wait_done(dc, coll);
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL floor_clear: coll=%b expected 0", coll);
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    int first = -1;
    int second = -1;
    field_mem = '0;
    start_scan(5'd2, 5'd3, 10'd0, 16'h0033);
    for (int k = 1; k <= 40; k++) begin
      start = (k == 5 || k == 19 || k == 20);
      if (k == 5 || k == 19) begin pos_x = 5'd9; pos_y = 5'd9; end
      if (k == 20) begin pos_x = 5'd4; pos_y = 5'd1; end
      if (k == 6) begin
        checks++;
        if ({pos_x_o, pos_y_o} !== {5'd2, 5'd3}) begin
          errors++;
          $display("FAIL b2b_latch_hold: pos_o=(%0d,%0d) expected (2,3)", pos_x_o, pos_y_o);
        end
      end
      if (k == 21) begin
        checks++;
        if ({pos_x_o, pos_y_o} !== {5'd4, 5'd1}) begin
          errors++;
          $display("FAIL b2b_relatch: pos_o=(%0d,%0d) expected (4,1)", pos_x_o, pos_y_o);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (first < 0) first = k; else second = k;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (n_done !== 2 || first !== 19 || second !== 39) begin
      errors++;
      $display("FAIL b2b_done: count=%0d at %0d,%0d expected 2 at 19,39", n_done, first, second);
    end
  endtask

  task automatic test_mid_reset();
    int n_done = 0;
    field_mem = '0;
    field_mem[0] = 1'b1;
    start_scan(5'd0, 5'd0, 10'd0, 16'h0033);
    for (int k = 1; k < 10; k++) step();
    checks++;
    if (busy !== 1'b1 || collision !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: busy=%b coll=%b expected 1/1", busy, collision);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, collision, b_x, b_y} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_post: busy/coll/bx/by=%b expected 000000", {busy, collision, b_x, b_y});
    end
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL midrst_nodone: %0d done pulses expected 0", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settled();
    test_wall_floor();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
